// File: rtl/leaf_user_rx_adapter.sv
// rtl/leaf_user_rx_adapter.sv - vld/ack receive word stream to FWFT ap_fifo-style read port
module leaf_user_rx_adapter #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH_BITS   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    empty_n,
  input  logic                    read,
  output logic                    almost_full,
  output logic [DEPTH_BITS:0]     level,
  output logic [31:0]             word_cnt
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   DEPTH_L = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   AFULL_L = (DEPTH_BITS+1)'(AFULL_THRESH);
  localparam logic [DEPTH_BITS:0]   ONE_L   = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr_nx;
  logic [DEPTH_BITS:0]     level_next;
  logic                    push;
  logic                    pop;

  // rd_ptr always addresses the entry currently presented on dout; the
  // array keeps every buffered word, including the head.
  assign push      = vld_interface2user && ack_user2interface;
  assign pop       = read && empty_n;
  assign rd_ptr_nx = rd_ptr + PTR_ONE;

  // Occupancy after this edge; all registered flags derive from it so that
  // ack drops exactly when the last slot is claimed and no push is lost.
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + ONE_L;
    end else if (pop && !push) begin
      level_next = level - ONE_L;
    end
  end

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk_user) begin
    if (push) begin
      mem[wr_ptr] <= dout_leaf_interface2user;
    end
  end

  // Pointers, counters, flags and the registered head-of-buffer word.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      level              <= '0;
      ack_user2interface <= 1'b0;
      empty_n            <= 1'b0;
      almost_full        <= 1'b0;
      word_cnt           <= '0;
      dout               <= '0;
    end else begin
      level              <= level_next;
      ack_user2interface <= (level_next < DEPTH_L);
      empty_n            <= (level_next != '0);
      almost_full        <= (level_next >= AFULL_L);
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        word_cnt <= word_cnt + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nx;
      end
      if (level == '0) begin
        // Empty: an incoming word falls straight through to the output.
        if (push) begin
          dout <= dout_leaf_interface2user;
        end
      end else if (pop) begin
        // Head consumed: next stored entry, or the word arriving this cycle
        // when the head was the only one buffered.
        if (level == ONE_L) begin
          if (push) begin
            dout <= dout_leaf_interface2user;
          end
        end else begin
          dout <= mem[rd_ptr_nx];
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_user_rx_adapter.sv
// tb/tb_leaf_user_rx_adapter.sv - directed and random checks of leaf_user_rx_adapter against a queue model
module tb_leaf_user_rx_adapter;

  localparam int PW    = 32;
  localparam int DB    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;

  logic          clk_user = 1'b0;
  logic          reset_n;
  logic [PW-1:0] din;
  logic          vld;
  logic          ack;
  logic [PW-1:0] dout;
  logic          empty_n;
  logic          rd;
  logic          almost_full;
  logic [DB:0]   level;
  logic [31:0]   word_cnt;

  leaf_user_rx_adapter #(
    .PAYLOAD_BITS(PW),
    .DEPTH_BITS  (DB),
    .AFULL_THRESH(AFT)
  ) dut (
    .clk_user                (clk_user),
    .reset_n                 (reset_n),
    .dout_leaf_interface2user(din),
    .vld_interface2user      (vld),
    .ack_user2interface      (ack),
    .dout                    (dout),
    .empty_n                 (empty_n),
    .read                    (rd),
    .almost_full             (almost_full),
    .level                   (level),
    .word_cnt                (word_cnt)
  );

  always #5 clk_user = ~clk_user;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is just an ordered queue of accepted words.
  logic [PW-1:0] q[$];
  logic [PW-1:0] popped[$];
  int unsigned   m_cnt;
  bit            m_started;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ack();
    return m_started && (q.size() < DEPTH);
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ":ack"}, 64'(ack), 64'(exp_ack()));
    chk({tag, ":empty_n"}, 64'(empty_n), 64'(q.size() != 0));
    chk({tag, ":level"}, 64'(level), 64'(q.size()));
    chk({tag, ":almost_full"}, 64'(almost_full), 64'(q.size() >= AFT));
    chk({tag, ":word_cnt"}, 64'(word_cnt), 64'(m_cnt));
    if (q.size() != 0) chk({tag, ":dout"}, 64'(dout), 64'(q[0]));
  endtask

  // One clock: drive inputs, let the edge happen, update model, check.
  task automatic step(input string tag, input bit v, input logic [PW-1:0] d, input bit r,
                      output bit pushed);
    bit do_pop;
    vld    = v;
    din    = d;
    rd     = r;
    pushed = v && exp_ack();
    do_pop = r && (q.size() != 0);
    @(posedge clk_user);
    if (do_pop) popped.push_back(q.pop_front());
    if (pushed) begin
      q.push_back(d);
      m_cnt++;
    end
    m_started = 1'b1;
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    bit unused;
    reset_n = 1'b0;
    #1;
    q.delete();
    m_cnt     = 0;
    m_started = 1'b0;
    chk({tag, ":rst_ack"}, 64'(ack), 64'd0);
    chk({tag, ":rst_empty_n"}, 64'(empty_n), 64'd0);
    chk({tag, ":rst_dout"}, 64'(dout), 64'd0);
    chk({tag, ":rst_almost_full"}, 64'(almost_full), 64'd0);
    chk({tag, ":rst_level"}, 64'(level), 64'd0);
    chk({tag, ":rst_word_cnt"}, 64'(word_cnt), 64'd0);
    repeat (2) @(posedge clk_user);
    #1;
    chk({tag, ":rst_hold_ack"}, 64'(ack), 64'd0);
    reset_n = 1'b1;
    step({tag, ":release"}, 1'b0, '0, 1'b0, unused);
    chk({tag, ":ack_after_release"}, 64'(ack), 64'd1);
  endtask

  initial begin
    bit          pushed;
    int          idx;
    int          rd_pct;
    int          vld_pct;
    logic [PW-1:0] nxt;

    reset_n   = 1'b1;
    vld       = 1'b1;
    din       = 32'hDEAD_BEEF;
    rd        = 1'b0;
    m_cnt     = 0;
    m_started = 1'b0;
    #2;

    // Reset with a word offered on the bus: nothing may be consumed.
    do_reset("reset");

    // First-word-fall-through latency.
    step("fwft_push", 1'b1, 32'h0000_0001, 1'b0, pushed);
    chk("fwft_dout", 64'(dout), 64'h1);
    chk("fwft_level", 64'(level), 64'd1);
    step("fwft_pop", 1'b0, '0, 1'b1, pushed);
    chk("fwft_empty", 64'(empty_n), 64'd0);

    // Fill with words 0..19 offered in order; unaccepted word stays on the bus.
    do_reset("fill_rst");
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      step("fill", 1'b1, 32'(idx), 1'b0, pushed);
      if (pushed) idx++;
    end
    chk("fill_accepted", 64'(idx), 64'd16);
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_ack", 64'(ack), 64'd0);
    chk("fill_afull", 64'(almost_full), 64'd1);
    chk("fill_cnt", 64'(word_cnt), 64'd16);

    // One pop while full reopens ack, then the held word 16 goes in.
    popped.delete();
    step("full_pop", 1'b1, 32'd16, 1'b1, pushed);
    chk("full_pop_noaccept", 64'(pushed), 64'd0);
    chk("full_pop_ack", 64'(ack), 64'd1);
    step("full_push16", 1'b1, 32'd16, 1'b0, pushed);
    chk("full_push16_accepted", 64'(pushed), 64'd1);
    popped.delete();
    for (int c = 0; c < 20 && q.size() != 0; c++) step("drain", 1'b0, '0, 1'b1, pushed);
    chk("drain_count", 64'(popped.size()), 64'd16);
    for (int i = 0; i < popped.size(); i++) chk("drain_order", 64'(popped[i]), 64'(i + 1));

    // Streaming push+pop every cycle from empty.
    do_reset("stream_rst");
    popped.delete();
    idx = 0;
    for (int c = 0; c < 300 && idx < 100; c++) begin
      step("stream", 1'b1, 32'(idx) + 32'h100, 1'b1, pushed);
      if (pushed) idx++;
      if (level > 1) chk("stream_level_le1", 64'(level), 64'd1);
    end
    for (int c = 0; c < 4 && q.size() != 0; c++) step("stream_drain", 1'b0, '0, 1'b1, pushed);
    chk("stream_cnt", 64'(word_cnt), 64'd100);
    chk("stream_popped", 64'(popped.size()), 64'd100);
    for (int i = 0; i < popped.size(); i++) chk("stream_order", 64'(popped[i]), 64'(i) + 64'h100);

    // Random traffic with phases of differing pressure so both full and empty occur.
    do_reset("rand_rst");
    nxt = $urandom;
    for (int c = 0; c < 10000; c++) begin
      case ((c / 500) % 3)
        0: begin vld_pct = 80; rd_pct = 30; end
        1: begin vld_pct = 30; rd_pct = 80; end
        default: begin vld_pct = 60; rd_pct = 60; end
      endcase
      step("rand", ($urandom_range(99) < vld_pct), nxt, ($urandom_range(99) < rd_pct), pushed);
      if (pushed) nxt = $urandom;
    end

    // Asynchronous reset in the middle of a burst, away from the clock edge.
    for (int c = 0; c < 10; c++) begin
      step("burst", 1'b1, $urandom, 1'b0, pushed);
    end
    #3;
    do_reset("midburst_rst");
    for (int c = 0; c < 5; c++) step("post_rst", 1'b1, 32'(c) + 32'hA0, 1'b0, pushed);
    chk("post_rst_cnt", 64'(word_cnt), 64'd5);
    chk("post_rst_head", 64'(dout), 64'hA0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/leaf_user_rx_adapter.md
Name: leaf_user_rx_adapter

Overview:
- Per-port receive adapter in the leaf shell, sitting directly downstream of leaf_interface's interface2user outputs (one instance per input port) and upstream of the HLS user kernel.
- Converts the vld/ack word handshake into an ap_fifo-style read interface (dout / empty_n / read) through a first-word-fall-through buffer.
- Provides fill level, almost-full and accepted-word count for per-port debug and back-pressure monitoring.
- Runs entirely in the user clock domain; all CDC is already handled inside leaf_interface.

Parameters:
- PAYLOAD_BITS, 32, data word width; matches leaf_interface PAYLOAD_BITS.
- DEPTH_BITS, 4, log2 of buffer depth (DEPTH = 2^DEPTH_BITS = 16); legal range 1..10.
- AFULL_THRESH, 12, almost_full asserts when level >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- clk_user, input, 1, user kernel clock; all logic is rising-edge.
- reset_n, input, 1, asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- dout_leaf_interface2user, input, PAYLOAD_BITS, word from leaf_interface.
- vld_interface2user, input, 1, word valid from leaf_interface.
- ack_user2interface, output, 1, ready to accept; a word transfers in any cycle where vld && ack.
- dout, output, PAYLOAD_BITS, head-of-buffer word to kernel.
- empty_n, output, 1, buffer not empty; dout is valid while high.
- read, input, 1, kernel pops the head word in any cycle where read && empty_n.
- almost_full, output, 1, level >= AFULL_THRESH.
- level, output, DEPTH_BITS+1, current occupancy, 0..DEPTH.
- word_cnt, output, 32, total accepted words; wraps modulo 2^32.

Behaviour:
- Reset (async assert, release synchronised by the caller):
  - ack=0, empty_n=0, dout=0, almost_full=0, level=0, word_cnt=0.
  - Read and write pointers = 0.
- Storage: DEPTH x PAYLOAD_BITS array with write/read pointers of DEPTH_BITS bits each, wrapping naturally from DEPTH-1 to 0. Level is held in a separate counter.
- push = vld_interface2user && ack_user2interface.
- pop = read && empty_n; read while empty_n=0 is ignored with no state change.
- level_next = level + push - pop. Simultaneous push and pop leave level unchanged; both pointers advance.
- ack_user2interface is registered: ack <= (level_next < DEPTH). There is no combinational path from vld or read to ack.
  - ack rises on the first clk_user edge after reset release.
  - Because ack is computed from level_next, a push is never lost, including the push that fills the last slot.
  - A pop while full re-asserts ack on the next cycle.
- FWFT / latency:
  - A word pushed at edge t is visible on dout with empty_n=1 after edge t (cycle t+1) when the buffer was empty.
  - dout and empty_n are registered outputs, not a combinational array read.
  - The output register reloads on pop from the next entry, or from the incoming word when the buffer holds exactly 1 and push && pop occur together.
- empty_n <= (level_next != 0).
- almost_full <= (level_next >= AFULL_THRESH).
- level output = registered level.
- word_cnt increments by 1 on each push and wraps 0xFFFFFFFF -> 0. It is not affected by pop.
- Words leave in strict arrival order; no word is duplicated or dropped under any push/pop interleaving.
- vld_interface2user high while ack=0: the word is held by the source and not consumed. Data-in is a don't-care while vld=0.
- Reset mid-operation: buffered contents are discarded and all outputs return to their reset values immediately (async). After release, behaviour is identical to a fresh start.

Test Plan:
- Reset: hold reset_n=0 while driving vld=1 and data 0xDEADBEEF -> ack=0, empty_n=0, level=0, word_cnt=0. Release -> ack=1 after one edge.
- FWFT latency: push 0x00000001 at edge t with read=0 -> at cycle t+1 empty_n=1, dout=0x00000001, level=1. Pulse read -> empty_n=0 the next cycle.
- Fill: continuous vld with data 0..19, read=0:
  - exactly 16 words accepted; ack falls the cycle after the 16th push; level=16;
  - almost_full=1 from level 12 onward; word_cnt=16;
  - word 16 is held on the bus.
- Full then drain: from the fill state, assert read for 1 cycle -> ack=1 the next cycle, word 16 accepted. Draining all 16 yields dout sequence 1..16 in order (word 0 was popped first).
- Streaming: vld=1 and read=1 every cycle for 100 words, starting empty -> level stays at or below 1, output order matches input order, word_cnt=100.
- Random: random vld/read over 10k cycles against a scoreboard -> no loss, duplication or reorder. Then assert reset_n=0 mid-burst -> outputs reset immediately, and a post-release stream starts clean at word_cnt=0.
